mem_arbiter: RTL and testbench

Two-port arbiter that shares the single main-memory port between the instruction cache and the data cache. It sits between both cache controllers and the main memory. It forwards one block-wide read or write at a time and returns the memory's ready pulse and read line to the granted requester only. Arbitration is round-robin by default. A one-cycle release gap separates consecutive memory transactions.

---
 rtl/mem_arbiter.sv | 87 ++++++++
 tb/tb_mem_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between I/D caches, round-robin (fixed D priority with MEM_ARB_DPRIO_EN)
module mem_arbiter #(
    parameter int Word_Size  = 32,
    parameter int Block_Size = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            i_read,
    input  logic                            i_write,
    input  logic [Word_Size-1:0]            i_addr,
    input  logic [Word_Size*Block_Size-1:0] i_wdata,
    output logic [Word_Size*Block_Size-1:0] i_rdata,
    output logic                            i_ready,
    input  logic                            d_read,
    input  logic                            d_write,
    input  logic [Word_Size-1:0]            d_addr,
    input  logic [Word_Size*Block_Size-1:0] d_wdata,
    output logic [Word_Size*Block_Size-1:0] d_rdata,
    output logic                            d_ready,
    output logic                            mem_read,
    output logic                            mem_write,
    output logic [Word_Size-1:0]            mem_addr,
    output logic [Word_Size*Block_Size-1:0] mem_wdata,
    input  logic [Word_Size*Block_Size-1:0] mem_rdata,
    input  logic                            mem_ready,
    output logic                            grant_i,
    output logic                            grant_d,
    output logic                            busy
);
    localparam logic [1:0] IDLE = 2'd0, GRANT_I = 2'd1, GRANT_D = 2'd2, RELEASE = 2'd3;
    logic [1:0] state;
    logic pend_i, pend_d, tie_d, sel_d, done;
    assign pend_i = i_read | i_write;
    assign pend_d = d_read | d_write;
    assign sel_d  = pend_d & (~pend_i | tie_d);
    assign done   = mem_ready & (state == GRANT_I || state == GRANT_D);
    assign busy   = state != IDLE;
`ifdef MEM_ARB_DPRIO_EN
    assign tie_d = 1'b1;
`else
    logic last_d;
    assign tie_d = ~last_d;
    always_ff @(posedge clk or negedge reset)
        if (!reset) last_d <= 1'b0;
        else if (done) last_d <= state == GRANT_D;
`endif
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            grant_i   <= 1'b0;
            grant_d   <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_ready   <= 1'b0;
            d_ready   <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            if (state == IDLE && (pend_i || pend_d)) begin
                state     <= sel_d ? GRANT_D : GRANT_I;
                grant_i   <= ~sel_d;
                grant_d   <= sel_d;
                mem_addr  <= sel_d ? d_addr : i_addr;
                mem_wdata <= sel_d ? d_wdata : i_wdata;
                mem_write <= sel_d ? d_write : i_write;
                mem_read  <= sel_d ? ~d_write : ~i_write;
            end else if (done) begin
                state     <= RELEASE;
                grant_i   <= 1'b0;
                grant_d   <= 1'b0;
                mem_read  <= 1'b0;
                mem_write <= 1'b0;
                i_ready   <= state == GRANT_I;
                d_ready   <= state == GRANT_D;
                // read data only replaces the held line when the finished op was a read
                if (mem_read && state == GRANT_I) i_rdata <= mem_rdata;
                if (mem_read && state == GRANT_D) d_rdata <= mem_rdata;
            end else if (state == RELEASE) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter grant order, timing, release gap and reset behaviour
module tb_mem_arbiter;
    localparam int LW = 128;
    logic clk = 1'b0;
    logic reset;
    logic i_read, i_write, d_read, d_write, mem_ready;
    logic [31:0] i_addr, d_addr;
    logic [LW-1:0] i_wdata, d_wdata, mem_rdata;
    logic [LW-1:0] i_rdata, d_rdata, mem_wdata;
    logic i_ready, d_ready, mem_read, mem_write, grant_i, grant_d, busy;
    logic [31:0] mem_addr;
    int total = 0;
    int bad = 0;
    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_ready(i_ready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .grant_i(grant_i), .grant_d(grant_d), .busy(busy)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic serve(input string tag, input bit exp_d, input int lat, input logic [LW-1:0] line);
        int n = 0;
        while (!(grant_i || grant_d) && n < 10) begin
            tick();
            n++;
        end
        check({tag, "_gd"}, LW'(grant_d), LW'(exp_d));
        check({tag, "_gi"}, LW'(grant_i), LW'(!exp_d));
        repeat (lat - 1) tick();
        mem_ready = 1'b1;
        mem_rdata = line;
        tick();
        mem_ready = 1'b0;
        check({tag, "_rdy"}, LW'(exp_d ? d_ready : i_ready), LW'(1));
        check({tag, "_dat"}, exp_d ? d_rdata : i_rdata, line);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog");
        $fatal(1);
    end
    initial begin
        bit e;
        reset = 1'b0;
        {i_read, i_write, d_read, d_write, mem_ready} = '0;
        i_addr = '0; d_addr = '0; i_wdata = '0; d_wdata = '0; mem_rdata = '0;
        #12;
        check("rst_oe", LW'(mem_read), '0);
        check("rst_we", LW'(mem_write), '0);
        check("rst_busy", LW'(busy), '0);
        check("rst_addr", LW'(mem_addr), '0);
        check("rst_irdata", i_rdata, '0);
        @(posedge clk);
        #1 reset = 1'b1;
        // single I read, memory ready after 5 cycles
        i_read = 1'b1;
        i_addr = 32'h40;
        tick();
        check("t1_addr", LW'(mem_addr), LW'(32'h40));
        check("t1_gi", LW'(grant_i), LW'(1));
        check("t1_we", LW'(mem_write), '0);
        for (int i = 0; i < 5; i++) begin
            check("t1_oe", LW'(mem_read), LW'(1));
            check("t1_irdy_early", LW'(i_ready), '0);
            if (i == 4) begin
                mem_ready = 1'b1;
                mem_rdata = {16{8'hA5}};
            end
            tick();
        end
        mem_ready = 1'b0;
        check("t1_irdy", LW'(i_ready), LW'(1));
        check("t1_irdata", i_rdata, {16{8'hA5}});
        check("t1_drdy", LW'(d_ready), '0);
        check("t1_oe_off", LW'(mem_read), '0);
        check("t1_rel_busy", LW'(busy), LW'(1));
        i_read = 1'b0;
        tick();
        check("t1_irdy_once", LW'(i_ready), '0);
        check("t1_idle", LW'(busy), '0);
        check("t1_hold", i_rdata, {16{8'hA5}});
        // D write
        d_write = 1'b1;
        d_addr = 32'h100;
        d_wdata = {4{32'h12345678}};
        tick();
        check("t2_we", LW'(mem_write), LW'(1));
        check("t2_oe", LW'(mem_read), '0);
        check("t2_addr", LW'(mem_addr), LW'(32'h100));
        check("t2_wdata", mem_wdata, {4{32'h12345678}});
        check("t2_gd", LW'(grant_d), LW'(1));
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        d_write = 1'b0;
        check("t2_drdy", LW'(d_ready), LW'(1));
        check("t2_rel_en", LW'({mem_read, mem_write}), '0);
        check("t2_rel_busy", LW'(busy), LW'(1));
        check("t2_drdata", d_rdata, '0);
        tick();
        check("t2_idle", LW'(busy), '0);
        check("t2_drdy_once", LW'(d_ready), '0);
        // read+write together is a write
        d_read = 1'b1;
        d_write = 1'b1;
        tick();
        check("t4_we", LW'(mem_write), LW'(1));
        check("t4_oe", LW'(mem_read), '0);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        {d_read, d_write} = '0;
        tick();
        // I request dropped mid-grant
        i_read = 1'b1;
        i_addr = 32'h80;
        tick();
        tick();
        i_read = 1'b0;
        tick();
        tick();
        check("t5_oe_held", LW'(mem_read), LW'(1));
        check("t5_gi_held", LW'(grant_i), LW'(1));
        check("t5_addr", LW'(mem_addr), LW'(32'h80));
        mem_ready = 1'b1;
        mem_rdata = {4{32'hCAFE0001}};
        tick();
        mem_ready = 1'b0;
        check("t5_irdy", LW'(i_ready), LW'(1));
        tick();
        check("t5_idle", LW'(busy), '0);
        tick();
        check("t5_stay_idle", LW'({grant_i, grant_d, busy}), '0);
        // mem_ready while idle is ignored
        mem_ready = 1'b1;
        mem_rdata = '1;
        tick();
        mem_ready = 1'b0;
        check("t7_rdy", LW'({i_ready, d_ready}), '0);
        check("t7_busy", LW'(busy), '0);
        check("t7_irdata", i_rdata, {4{32'hCAFE0001}});
        // ties from reset
        reset = 1'b0;
        tick();
        reset = 1'b1;
        i_read = 1'b1;
        d_read = 1'b1;
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_DPRIO_EN
            e = 1'b1;
`else
            e = (k % 2) == 0;
`endif
            serve($sformatf("t3_tie%0d", k), e, 2, {4{32'(k + 1)}});
        end
        i_read = 1'b0;
        d_read = 1'b0;
        tick();
        tick();
        // async reset during GRANT_D
        d_read = 1'b1;
        tick();
        check("t6_gd", LW'(grant_d), LW'(1));
        #2 reset = 1'b0;
        #1;
        check("t6_en", LW'({mem_read, mem_write}), '0);
        check("t6_gd_off", LW'(grant_d), '0);
        check("t6_busy", LW'(busy), '0);
        d_read = 1'b0;
        tick();
        check("t6_drdy", LW'(d_ready), '0);
        reset = 1'b1;
        i_read = 1'b1;
        serve("t6_after", 1'b0, 3, {8{16'h5A5A}});
        i_read = 1'b0;
        tick();
        check("t6_idle", LW'(busy), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
